mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory stage of the pipelined ARM core. Sits directly downstream of the EX/MEM pipeline register and consumes its M-stage outputs.
- Performs the data-memory access over a req/ack bus with variable latency, and stalls the front of the pipeline until the access completes.
- Contains the MEM/WB pipeline register and drives the W-stage result mux for the register file.

Parameters:
- TIMEOUT, 16: maximum number of WAIT cycles without mem_ack before the access is aborted. Used only with MEM_TIMEOUT_EN. Legal range is 2..256.

Ports:
- clk  in  1  system clock; all state updates on the falling edge, matching the rest of the pipeline.
- reset  in  1  synchronous, active-high reset.
- RegWriteM  in  1  register-write enable from EX/MEM.
- MemtoRegM  in  1  selects the memory read data as the result.
- MemWriteM  in  1  store write enable.
- LoadM  in  1  instruction in M is a load.
- StoreM  in  1  instruction in M is a store.
- WriteAddrM  in  4  destination register number.
- WriteDataM  in  32  store data.
- ALUResultM  in  32  effective address, or the ALU result for non-memory ops.
- mem_req  out  1  memory request (registered).
- mem_we  out  1  1 = write (registered).
- mem_addr  out  32  word address, {ALUResultM[31:2],2'b00} (registered).
- mem_wdata  out  32  store data (registered).
- mem_rdata  in  32  read data, valid when mem_ack=1.
- mem_ack  in  1  access complete.
- StallM  out  1  hold PC, IF/ID, ID/EX and EX/MEM (combinational).
- RegWriteW  out  1  MEM/WB register output.
- MemtoRegW  out  1  MEM/WB register output.
- WriteAddrW  out  4  MEM/WB register output.
- ReadDataW  out  32  MEM/WB register output.
- ALUOutW  out  32  MEM/WB register output.
- ResultW  out  32  MemtoRegW ? ReadDataW : ALUOutW (combinational).
- BusErrW  out  1  sticky timeout flag; exists only with MEM_TIMEOUT_EN.

Behaviour:
- Interface decision: one clock, clk. Reset is synchronous and active-high, port name reset.
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, all W-stage registers 0, counter 0, BusErrW=0.
- Reset mid-access: the access is abandoned. mem_req is 0 after the reset edge, and any mem_ack arriving after that is ignored.
- memop = LoadM | StoreM.

FSM, IDLE:
- memop=0: MEM/WB loads the M-stage fields; ReadDataW=0. Non-memory ops have 1-cycle latency and StallM=0.
- memop=1: StallM=1. At the edge, capture mem_addr and mem_wdata, set mem_we=StoreM and MemWriteM, set mem_req=1, clear the counter, go to WAIT. MEM/WB loads a bubble (RegWriteW=0, MemtoRegW=0, other fields 0).

FSM, WAIT:
- mem_req is held at 1, and mem_addr, mem_we and mem_wdata are held stable.
- mem_ack=0: StallM=1, counter increments, MEM/WB loads a bubble.
- mem_ack=1: StallM=0 in that same cycle, so EX/MEM advances at the same edge the access retires. At that edge:
  - MEM/WB loads RegWriteM, MemtoRegM, WriteAddrM and ALUResultM.
  - ReadDataW=mem_rdata for a load, 0 for a store.
  - mem_req=0, mem_we=0, go to IDLE.
- An op is never issued twice: the retiring edge also advances EX/MEM.
- Minimum memory-op latency is 2 cycles (1 stall cycle). Back-to-back memory ops leave mem_req low for one IDLE cycle between them.

Other rules:
- mem_ack while mem_req=0 is ignored.
- StallM is a function of state, memop and mem_ack only; it never depends on W-stage state.
- ResultW follows the MEM/WB registers combinationally.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - In WAIT, when the counter reaches TIMEOUT-1 with mem_ack=0, the access aborts at that edge. StallM=0 in that cycle.
  - Abort actions: mem_req=0, go to IDLE. MEM/WB loads the instruction with RegWriteW forced to 0 and ReadDataW=0. BusErrW is set to 1 and stays set until reset.
  - mem_ack and the timeout in the same cycle: mem_ack wins, normal retire, BusErrW unchanged.
- Not defined:
  - WAIT lasts until mem_ack with no limit.
  - No counter logic; the BusErrW port is absent.

Test Plan:
- ALU op, no memop (RegWriteM=1, WriteAddrM=3, ALUResultM=0x0000_0042) -> next edge RegWriteW=1, WriteAddrW=3, ResultW=0x42; StallM never 1.
- Load from 0x100, mem_ack after 3 WAIT cycles with mem_rdata=0xCAFEF00D -> StallM=1 for 3 cycles, drops when ack=1; mem_addr=0x100 stable throughout; ResultW=0xCAFEF00D one edge later.
- Store 0x12345678 to 0x203 (mem_ack in first WAIT cycle) -> mem_we=1, mem_addr=0x200, mem_wdata=0x12345678; 1 stall cycle; RegWriteW=0.
- Back-to-back loads to 0x10 and 0x14 -> two separate req pulses with one IDLE gap; each address is requested once; both results retire in order.
- reset asserted during WAIT of a load -> mem_req=0 after the edge; a later mem_ack=1 causes no W-stage write; StallM=0.
- MEM_TIMEOUT_EN, TIMEOUT=4, no ack -> abort after 4 WAIT cycles; BusErrW=1 (sticky); RegWriteW=0; pipeline resumes.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: issues the data access on the req/ack bus, stalls M until it retires, holds MEM/WB.
// Optional MEM_TIMEOUT_EN aborts an access after TIMEOUT WAIT cycles and sets a sticky BusErrW.
module mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic        LoadM,
  input  logic        StoreM,
  input  logic [3:0]  WriteAddrM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALUResultM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        StallM,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [3:0]  WriteAddrW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
`ifdef MEM_TIMEOUT_EN
  output logic        BusErrW,
`endif
  output logic [31:0] ResultW
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q;
  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic        regwrite_w_q, memtoreg_w_q;
  logic [3:0]  writeaddr_w_q;
  logic [31:0] readdata_w_q, aluout_w_q;

  logic        memop;
  logic        abort;
  logic [31:0] rdata_d;

  assign memop = LoadM | StoreM;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt_q;
  logic          buserr_q;

  // ack in the last permitted cycle wins over the abort
  assign abort   = (state_q == S_WAIT) && !mem_ack && (cnt_q == CW'(TIMEOUT - 1));
  assign BusErrW = buserr_q;
`else
  assign abort = 1'b0;
`endif

  // StallM drops exactly on the edge where the M-stage instruction leaves, so MEM/WB loads iff !StallM
  assign StallM  = (state_q == S_IDLE) ? memop : (!mem_ack && !abort);
  assign rdata_d = ((state_q == S_WAIT) && mem_ack && LoadM) ? mem_rdata : 32'd0;

  always_ff @(negedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'd0;
      mem_wdata_q   <= 32'd0;
      regwrite_w_q  <= 1'b0;
      memtoreg_w_q  <= 1'b0;
      writeaddr_w_q <= 4'd0;
      readdata_w_q  <= 32'd0;
      aluout_w_q    <= 32'd0;
`ifdef MEM_TIMEOUT_EN
      cnt_q         <= '0;
      buserr_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (memop) begin
          mem_addr_q  <= {ALUResultM[31:2], 2'b00};
          mem_wdata_q <= WriteDataM;
          mem_we_q    <= StoreM & MemWriteM;
          mem_req_q   <= 1'b1;
          state_q     <= S_WAIT;
        end
        S_WAIT: if (mem_ack || abort) begin
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase

      if (!StallM) begin
        regwrite_w_q  <= RegWriteM & ~abort;
        memtoreg_w_q  <= MemtoRegM;
        writeaddr_w_q <= WriteAddrM;
        readdata_w_q  <= rdata_d;
        aluout_w_q    <= ALUResultM;
      end else begin
        regwrite_w_q  <= 1'b0;
        memtoreg_w_q  <= 1'b0;
        writeaddr_w_q <= 4'd0;
        readdata_w_q  <= 32'd0;
        aluout_w_q    <= 32'd0;
      end

`ifdef MEM_TIMEOUT_EN
      if (state_q == S_IDLE) cnt_q <= '0;
      else if (!mem_ack)     cnt_q <= cnt_q + 1'b1;
      if (abort) buserr_q <= 1'b1;
`endif
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign RegWriteW  = regwrite_w_q;
  assign MemtoRegW  = memtoreg_w_q;
  assign WriteAddrW = writeaddr_w_q;
  assign ReadDataW  = readdata_w_q;
  assign ALUOutW    = aluout_w_q;
  assign ResultW    = memtoreg_w_q ? readdata_w_q : aluout_w_q;

endmodule
